// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the synchronous byte-enabled data memory.
package dmem_pkg;

    typedef enum logic {
        DMEM_CLEAR,
        DMEM_IDLE
    } dmem_state_t;

    localparam int          DMEM_DATA_W     = 16;
    localparam int          BYTES           = DMEM_DATA_W / 8;
    localparam logic [63:0] DMEM_CLEAR_WORD = '0;

endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-port RAM, synchronous byte-enabled write, read word presented combinationally.
// Latency: write lands at the clock edge; rdata reflects the addressed word in the same cycle.
// Backpressure: none, the caller arbitrates the single port. DMEM_PARITY_EN adds per-byte even parity.
module dmem_array #(
    parameter int DATA_W     = 16,
    parameter int NBYTES     = DATA_W / 8,
    parameter int DEPTH      = 8192,
    parameter int IDX_W      = 13,
    parameter int READ_FIRST = 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [NBYTES-1:0] be,
    input  logic [IDX_W-1:0]  addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
`ifdef DMEM_PARITY_EN
    ,
    output logic              par_err
`endif
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] old_word;
    logic [DATA_W-1:0] new_word;

`ifdef DMEM_PARITY_EN
    logic [NBYTES-1:0] par_mem [DEPTH];
`endif

    always_ff @(posedge clk) begin
        for (int b = 0; b < NBYTES; b++) begin
            if (we && be[b]) begin
                mem[addr][8*b +: 8] <= wdata[8*b +: 8];
`ifdef DMEM_PARITY_EN
                par_mem[addr][b] <= ^wdata[8*b +: 8];
`endif
            end
        end
    end

    // new_word is what the array will hold after this edge's write
    always_comb begin
        old_word = mem[addr];
        new_word = old_word;
        for (int b = 0; b < NBYTES; b++) begin
            if (we && be[b]) begin
                new_word[8*b +: 8] = wdata[8*b +: 8];
            end
        end
        rdata = (READ_FIRST != 0) ? old_word : new_word;
    end

`ifdef DMEM_PARITY_EN
    // bytes returned straight from wdata carry fresh parity and cannot mismatch
    always_comb begin
        par_err = 1'b0;
        for (int b = 0; b < NBYTES; b++) begin
            if (!((READ_FIRST == 0) && we && be[b])) begin
                par_err = par_err | (^{old_word[8*b +: 8], par_mem[addr][b]});
            end
        end
    end
`endif

endmodule

// File: rtl/dmem_sync_be.sv
// dmem_sync_be: MEM-stage data memory with byte enables, range check and post-reset zero fill.
// Latency: read data and C_DMValid appear one cycle after the accepting edge; writes land at that edge.
// Backpressure: C_DMReady low during the clear sweep, requests then are dropped. DMEM_PARITY_EN adds C_DMParErr.
module dmem_sync_be
    import dmem_pkg::*;
#(
    parameter int DATA_W         = DMEM_DATA_W,
    parameter int ADDR_W         = 16,
    parameter int DEPTH          = 8192,
    parameter int READ_FIRST     = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                C_DMRead,
    input  logic                C_DMWrite,
    input  logic [DATA_W/8-1:0] C_ByteEn,
    input  logic [ADDR_W-1:0]   A_DataAddress,
    input  logic [DATA_W-1:0]   D_WriteData,
    output logic [DATA_W-1:0]   D_Data,
    output logic                C_DMReady,
    output logic                C_DMValid,
    output logic                C_DMAddrErr
`ifdef DMEM_PARITY_EN
    ,
    output logic                C_DMParErr
`endif
);

    localparam int              NBYTES  = DATA_W / 8;
    localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_L  = (ADDR_W+1)'(DEPTH - 1);
    localparam dmem_state_t     RST_ST  = (CLEAR_ON_RESET != 0) ? DMEM_CLEAR : DMEM_IDLE;

    dmem_state_t       state, state_nxt;
    logic [ADDR_W:0]   ptr, ptr_nxt;
    logic              in_range;
    logic              accept;
    logic              acc_rd;
    logic              clearing;
    logic              arr_we;
    logic [NBYTES-1:0] arr_be;
    logic [IDX_W-1:0]  arr_addr;
    logic [DATA_W-1:0] arr_wdata;
    logic [DATA_W-1:0] arr_rdata;
`ifdef DMEM_PARITY_EN
    logic              arr_par_err;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RST_ST;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        case (state)
            DMEM_CLEAR: begin
                ptr_nxt = ptr + (ADDR_W+1)'(1);
                if (ptr == LAST_L) begin
                    state_nxt = DMEM_IDLE;
                    ptr_nxt   = '0;
                end
            end
            default: ;
        endcase
    end

    assign clearing = (state == DMEM_CLEAR);
    assign in_range = ({1'b0, A_DataAddress} < DEPTH_L);
    assign accept   = C_DMReady & (C_DMRead | C_DMWrite);
    assign acc_rd   = accept & C_DMRead;

    // the clear sweep owns the single array port; out-of-range writes never reach it
    assign arr_we    = clearing | (accept & C_DMWrite & in_range);
    assign arr_be    = clearing ? {NBYTES{1'b1}} : C_ByteEn;
    assign arr_addr  = clearing ? ptr[IDX_W-1:0] : A_DataAddress[IDX_W-1:0];
    assign arr_wdata = clearing ? DATA_W'(DMEM_CLEAR_WORD) : D_WriteData;

    dmem_array #(
        .DATA_W     (DATA_W),
        .NBYTES     (NBYTES),
        .DEPTH      (DEPTH),
        .IDX_W      (IDX_W),
        .READ_FIRST (READ_FIRST)
    ) u_array (
        .clk     (clk),
        .we      (arr_we),
        .be      (arr_be),
        .addr    (arr_addr),
        .wdata   (arr_wdata),
        .rdata   (arr_rdata)
`ifdef DMEM_PARITY_EN
        ,
        .par_err (arr_par_err)
`endif
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            D_Data      <= '0;
            C_DMReady   <= 1'b0;
            C_DMValid   <= 1'b0;
            C_DMAddrErr <= 1'b0;
        end else begin
            C_DMReady   <= (state_nxt == DMEM_IDLE);
            C_DMValid   <= acc_rd;
            C_DMAddrErr <= accept & ~in_range;
            if (acc_rd) begin
                D_Data <= in_range ? arr_rdata : '0;
            end
        end
    end

`ifdef DMEM_PARITY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            C_DMParErr <= 1'b0;
        end else begin
            C_DMParErr <= acc_rd & in_range & arr_par_err;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_sync_be.sv
// tb_dmem_sync_be: scoreboard bench driving a READ_FIRST=1 and a READ_FIRST=0 instance in lockstep.
module tb_dmem_sync_be;
    import dmem_pkg::*;

    typedef struct {
        logic [15:0] d_rf;
        logic [15:0] d_wf;
        logic        ae;
        logic        pe_rf;
        int          cyc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             rd  = 1'b0;
    logic             wr  = 1'b0;
    logic [BYTES-1:0] be  = '0;
    logic [15:0]      addr = '0;
    logic [15:0]      wd   = '0;
    logic [15:0]      d_rf, d_wf;
    logic             rdy_rf, rdy_wf, v_rf, v_wf, ae_rf, ae_wf;
`ifdef DMEM_PARITY_EN
    logic             pe_rf, pe_wf;
`endif

    logic [15:0] model [16];
    exp_t        sb [$];
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    int          edges;

    always #5 clk = ~clk;

    dmem_sync_be #(.DATA_W(16), .ADDR_W(16), .DEPTH(16), .READ_FIRST(1), .CLEAR_ON_RESET(1)) dut_rf (
        .clk(clk), .rst(rst), .C_DMRead(rd), .C_DMWrite(wr), .C_ByteEn(be),
        .A_DataAddress(addr), .D_WriteData(wd), .D_Data(d_rf), .C_DMReady(rdy_rf),
        .C_DMValid(v_rf), .C_DMAddrErr(ae_rf)
`ifdef DMEM_PARITY_EN
        , .C_DMParErr(pe_rf)
`endif
    );

    dmem_sync_be #(.DATA_W(16), .ADDR_W(16), .DEPTH(16), .READ_FIRST(0), .CLEAR_ON_RESET(1)) dut_wf (
        .clk(clk), .rst(rst), .C_DMRead(rd), .C_DMWrite(wr), .C_ByteEn(be),
        .A_DataAddress(addr), .D_WriteData(wd), .D_Data(d_wf), .C_DMReady(rdy_wf),
        .C_DMValid(v_wf), .C_DMAddrErr(ae_wf)
`ifdef DMEM_PARITY_EN
        , .C_DMParErr(pe_wf)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s got=0x%0h exp=0x%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] nw,
                                          input logic [1:0] en);
        logic [15:0] r;
        r = old;
        if (en[0]) r[7:0]  = nw[7:0];
        if (en[1]) r[15:8] = nw[15:8];
        return r;
    endfunction

    // one request per call, occupying exactly one accepting edge
    task automatic drive(input logic r, input logic w, input logic [1:0] en,
                         input logic [15:0] a, input logic [15:0] d, input logic pe_exp = 1'b0);
        exp_t        e;
        logic [15:0] old;
        logic [15:0] nw;
        @(negedge clk);
        rd = r; wr = w; be = en; addr = a; wd = d;
        chk("rdy_at_req", {31'd0, rdy_rf}, 32'd1);
        old = (a < 16) ? model[a[3:0]] : 16'h0000;
        nw  = merge(old, d, w ? en : 2'b00);
        if (r) begin
            e.d_rf  = old;
            e.d_wf  = (a < 16) ? nw : 16'h0000;
            e.ae    = (a >= 16);
            e.pe_rf = pe_exp;
            e.cyc   = cyc + 1;
            sb.push_back(e);
        end
        if (w && a < 16) model[a[3:0]] = nw;
    endtask

    task automatic idle();
        @(negedge clk);
        rd = 1'b0; wr = 1'b0; be = '0;
    endtask

    task automatic wait_ready(output int n);
        bit seen;
        seen = 1'b0;
        n = -1;
        for (int k = 1; k <= 40; k++) begin
            if (!seen) begin
                @(posedge clk);
                #1;
                if (rdy_rf) begin
                    seen = 1'b1;
                    n = k;
                    rd = 1'b0; wr = 1'b0; be = '0;
                end
            end
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        cyc++;
        #1;
        if (v_rf || v_wf) begin
            chk("sb_pending", {31'd0, sb.size() > 0}, 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("vld_rf", {31'd0, v_rf}, 32'd1);
                chk("vld_wf", {31'd0, v_wf}, 32'd1);
                chk("latency", cyc, e.cyc);
                chk("d_rf", {16'd0, d_rf}, {16'd0, e.d_rf});
                chk("d_wf", {16'd0, d_wf}, {16'd0, e.d_wf});
                chk("aerr_rf", {31'd0, ae_rf}, {31'd0, e.ae});
                chk("aerr_wf", {31'd0, ae_wf}, {31'd0, e.ae});
`ifdef DMEM_PARITY_EN
                chk("perr_rf", {31'd0, pe_rf}, {31'd0, e.pe_rf});
                chk("perr_wf", {31'd0, pe_wf}, 32'd0);
`endif
            end
        end
    end

    initial begin
        for (int i = 0; i < 16; i++) model[i] = 16'h0000;
        repeat (3) @(negedge clk);
        chk("rst_rdy", {31'd0, rdy_rf}, 32'd0);
        chk("rst_vld", {31'd0, v_rf}, 32'd0);
        chk("rst_data", {16'd0, d_rf}, 32'd0);
        chk("rst_aerr", {31'd0, ae_rf}, 32'd0);

        // hold a read+write during the clear sweep; it must be ignored entirely
        rst = 1'b1;
        rd = 1'b1; wr = 1'b1; be = 2'b11; addr = 16'd5; wd = 16'hFFFF;
        wait_ready(edges);
        chk("clear_cycles", edges, 32'd16);
        chk("rdy_wf", {31'd0, rdy_wf}, 32'd1);

        drive(1, 0, 2'b11, 16'd5, 16'h0000);
        drive(0, 1, 2'b11, 16'd3, 16'hBEEF);
        drive(0, 1, 2'b10, 16'd3, 16'h1234);
        drive(1, 0, 2'b11, 16'd3, 16'h0000);
        drive(0, 1, 2'b11, 16'd7, 16'h1111);
        drive(1, 1, 2'b11, 16'd7, 16'h2222);
        drive(1, 0, 2'b11, 16'd7, 16'h0000);
        drive(0, 1, 2'b11, 16'd9, 16'h5566);
        drive(1, 1, 2'b10, 16'd9, 16'hAA00);
        drive(0, 1, 2'b00, 16'd4, 16'hFFFF);
        drive(0, 1, 2'b11, 16'd12, 16'hC0DE);
        drive(1, 0, 2'b11, 16'd16, 16'h0000);
        idle();

        drive(0, 1, 2'b11, 16'd16, 16'hDEAD);
        @(posedge clk);
        #1;
        chk("wo_oor_aerr", {31'd0, ae_rf}, 32'd1);
        chk("wo_oor_vld", {31'd0, v_rf}, 32'd0);
        idle();
        @(posedge clk);
        #1;
        chk("aerr_pulse_end", {31'd0, ae_rf}, 32'd0);

        for (int i = 0; i < 16; i++) drive(1, 0, 2'b11, 16'(i), 16'h0000);
        idle();
        repeat (3) @(negedge clk);
        chk("data_hold", {16'd0, d_rf}, {16'd0, model[15]});

        // reset again, interrupt the sweep at ptr=8, and check it restarts from zero
        @(negedge clk) rst = 1'b0;
        @(negedge clk) rst = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        chk("rst2_rdy", {31'd0, rdy_rf}, 32'd0);
        rst = 1'b1;
        for (int i = 0; i < 16; i++) model[i] = 16'h0000;
        wait_ready(edges);
        chk("reclear_cycles", edges, 32'd16);
        drive(1, 0, 2'b11, 16'd3, 16'h0000);
        drive(1, 0, 2'b11, 16'd12, 16'h0000);
        idle();

`ifdef DMEM_PARITY_EN
        drive(0, 1, 2'b11, 16'd2, 16'hA5A5);
        drive(0, 1, 2'b11, 16'd9, 16'h5566);
        idle();
        @(negedge clk);
        dut_rf.u_array.par_mem[2][0] = ~dut_rf.u_array.par_mem[2][0];
        drive(1, 0, 2'b11, 16'd2, 16'h0000, 1'b1);
        drive(1, 0, 2'b11, 16'd9, 16'h0000, 1'b0);
        idle();
`endif

        repeat (4) @(negedge clk);
        chk("sb_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_sync_be.md
Name: dmem_sync_be

Overview:
- Parametrised, clocked data memory for the processor's MEM stage. Successor to the combinational 16-bit data memory.
- Adds registered reads, per-byte write enables, read/write collision policy, a ready/valid handshake, an out-of-range address flag and a post-reset clear sequencer.
- Sits between the load/store unit and the data address bus. Control pins keep the C_/A_/D_ prefixes used by the existing datapath.

Parameters:
- DATA_W, 16: data word width in bits; must be a multiple of 8.
- ADDR_W, 16: address width in bits; word-addressed.
- DEPTH, 8192: number of words; must be 1..2**ADDR_W.
- READ_FIRST, 1: on a same-address read+write, 1 returns the old word and 0 returns the newly written word.
- CLEAR_ON_RESET, 1: 1 zero-fills the array after reset; 0 skips the clear.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- C_DMRead  in  1  read request.
- C_DMWrite  in  1  write request.
- C_ByteEn  in  DATA_W/8  per-byte write enable; bit i covers D_WriteData[8i+7:8i].
- A_DataAddress  in  ADDR_W  word address.
- D_WriteData  in  DATA_W  write data.
- D_Data  out  DATA_W  registered read data.
- C_DMReady  out  1  block accepts requests this cycle.
- C_DMValid  out  1  one-cycle pulse: D_Data and C_DMAddrErr are valid.
- C_DMAddrErr  out  1  address >= DEPTH on the request answered this cycle.

Behaviour:
- Reset (rst=0, asynchronous): state=CLEAR if CLEAR_ON_RESET else IDLE; clear pointer=0; D_Data=0; C_DMValid=0; C_DMReady=0; C_DMAddrErr=0. Array contents are not reset asynchronously.
- CLEAR state:
  - Each cycle writes 0 to word[ptr], then ptr+1.
  - After the write of ptr=DEPTH-1, goes to IDLE; DEPTH cycles total.
  - C_DMReady=0 throughout. Requests are ignored with no side effects and no C_DMValid.
- IDLE state:
  - C_DMReady=1 from the first cycle in IDLE, including the first cycle after reset release when CLEAR_ON_RESET=0.
  - A request is accepted on a rising edge with C_DMReady=1 and (C_DMRead or C_DMWrite).
- Write:
  - The word at the address is updated at the accepting edge, only for bytes whose C_ByteEn bit is 1.
  - C_ByteEn=0 is a no-op.
  - A write-only request produces no C_DMValid pulse.
- Read latency is 1 cycle:
  - D_Data is loaded at the accepting edge, and C_DMValid=1 for the following cycle only.
  - D_Data holds its last value until the next read; it is not cleared by C_DMValid falling.
- Read+write in the same request:
  - Both are performed.
  - READ_FIRST=1: D_Data = word before the write.
  - READ_FIRST=0: D_Data = merged word after applying the byte enables.
- Back-to-back reads are accepted every cycle; throughput is 1 per cycle.
- Out of range (A_DataAddress >= DEPTH): the write is dropped; a read returns D_Data=0 with C_DMValid=1 and C_DMAddrErr=1. A write-only out-of-range request pulses C_DMAddrErr for 1 cycle.
- C_DMAddrErr is 0 whenever C_DMValid is 0, except for the write-only pulse.
- Reset during CLEAR: restarts at ptr=0; partially cleared words are cleared again.
- Reset during an in-flight read: the pending C_DMValid is discarded.
- Address arithmetic: the clear pointer is ADDR_W+1 bits to avoid wrap at DEPTH=2**ADDR_W.

Optional Feature:
- Macro DMEM_PARITY_EN.
- Defined:
  - The array stores one even-parity bit per byte, computed on write and on clear.
  - On read, parity is checked per byte.
  - Extra output C_DMParErr (1 bit, reset 0) pulses with C_DMValid when any read byte mismatches.
  - The bench can corrupt parity via a hierarchical force.
- Undefined: no parity storage, no C_DMParErr port; behaviour otherwise identical.

Decomposition:
- Package dmem_pkg: state enum {DMEM_CLEAR, DMEM_IDLE}; localparam BYTES = DATA_W/8; clear value constant DMEM_CLEAR_WORD = 0.
- Sub-module dmem_array: single-port synchronous RAM with byte enables and a READ_FIRST parameter, plus the parity bits under the macro.
- Top-level dmem_sync_be holds the FSM, clear pointer, range check, handshake and output registers.

Test Plan:
- Reset with CLEAR_ON_RESET=1, DEPTH=16: C_DMReady=0 for 16 cycles then 1; a read of address 5 returns D_Data=0x0000 with C_DMValid 1 cycle later.
- Write 0xBEEF to address 3 with C_ByteEn=2'b11, then write 0x12xx with C_ByteEn=2'b10, then read address 3 -> D_Data=0x12EF.
- Read+write to address 7 (old 0x1111, new 0x2222): READ_FIRST=1 -> D_Data=0x1111; READ_FIRST=0 -> D_Data=0x2222; a later read returns 0x2222 in both cases.
- Read of address 16 with DEPTH=16 -> D_Data=0, C_DMValid=1, C_DMAddrErr=1; a write to address 16 leaves addresses 0-15 unchanged.
- Assert rst at clear ptr=8, release -> clear restarts and C_DMReady rises 16 cycles after release; requests during CLEAR produce no C_DMValid.
- With DMEM_PARITY_EN: write 0xA5A5, flip the stored parity bit of byte 0, read -> C_DMParErr=1 with C_DMValid; a clean word read -> C_DMParErr=0.
